// File: rtl/encode_reg_if.sv
// Request/response bundle for the R-type encoder: a request channel carrying
// an ALU op plus register indices, and a response channel carrying the
// encoded 32-bit instruction word. Both channels use valid/ready.
interface encode_reg_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_alu_control;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;

  // Producer of requests and consumer of encoded words.
  modport master (
    output in_valid, in_alu_control, in_rd, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_inst
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_alu_control, in_rd, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_inst
  );
endinterface

// File: rtl/encode_reg_inst.sv
// R-type instruction encoder: maps an ALU op and rd/rs1/rs2 onto an RV32I
// OP-class instruction word and queues it in a small FIFO. Unknown ALU codes
// are accepted, dropped, flagged for one cycle and counted (saturating).
module encode_reg_inst #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  encode_reg_if.slave              bus,
  output logic                     err_illegal,
  output logic [CNT_W-1:0]         illegal_count,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);
  localparam logic [6:0] OPC_OP = 7'b0110011;

  // ALU op codes shared with the decode path.
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9
  } alu_op_e;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level;

  logic        legal;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] enc_word;
  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        accept_illegal;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

  // Ready depends only on state and flush, never on in_valid; a full FIFO
  // stays not-ready even if the head is being popped this cycle.
  assign bus.in_ready  = !full && !flush;
  assign bus.out_valid = !empty;
  assign bus.out_inst  = empty ? '0 : mem[rd_ptr];

  assign accept         = bus.in_valid && bus.in_ready;
  assign push           = accept && legal;
  assign accept_illegal = accept && !legal;
  assign pop            = bus.out_valid && bus.out_ready && !flush;

  assign enc_word = {funct7, bus.in_rs2, bus.in_rs1, funct3, bus.in_rd, OPC_OP};

  // Translate the ALU op into funct3/funct7; unknown codes are illegal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    legal  = 1'b1;
    funct3 = 3'b000;
    funct7 = 7'h00;
    case (bus.in_alu_control)
      ALU_ADD:  funct3 = 3'b000;
      ALU_SUB:  begin funct3 = 3'b000; funct7 = 7'h20; end
      ALU_SLL:  funct3 = 3'b001;
      ALU_SLT:  funct3 = 3'b010;
      ALU_SLTU: funct3 = 3'b011;
      ALU_XOR:  funct3 = 3'b100;
      ALU_SRL:  funct3 = 3'b101;
      ALU_SRA:  begin funct3 = 3'b101; funct7 = 7'h20; end
      ALU_OR:   funct3 = 3'b110;
      ALU_AND:  funct3 = 3'b111;
      default:  legal  = 1'b0;
    endcase
  end

  // Storage array write port.
  // NOTE: the data array has no reset; occupancy is tracked by level and the
  // output is forced to zero when empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // FIFO pointers and occupancy; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Illegal-op pulse and saturating counter; the counter survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal   <= 1'b0;
      illegal_count <= '0;
    end else begin
      err_illegal <= accept_illegal;
      if (accept_illegal && (illegal_count != '1)) begin
        illegal_count <= illegal_count + 1'b1;
      end
    end
  end

  assign fill_level = level;

endmodule

// File: tb/tb_encode_reg_inst.sv
// Self-checking bench for encode_reg_inst: a queue-based reference model
// tracks expected FIFO contents, error pulse and counter; a compare process
// checks every cycle, and directed sequences pin literal instruction words.
module tb_encode_reg_inst;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_SRA = 5'd7;
  localparam logic [4:0] OP_AND = 5'd9;

  logic clk;
  logic rst_n;
  logic flush;
  logic err_illegal;
  logic [CNT_W-1:0] illegal_count;
  logic [$clog2(DEPTH):0] fill_level;

  encode_reg_if bus ();

  encode_reg_inst #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .bus           (bus),
    .err_illegal   (err_illegal),
    .illegal_count (illegal_count),
    .fill_level    (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference encoding from the funct3/funct7 table, built arithmetically.
  function automatic bit model_encode(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      output logic [31:0] w);
    int f3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    bit f7 [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    w = 32'h0;
    if (int'(op) > 9) return 1'b0;
    w = (f7[op] ? 32'h4000_0000 : 32'h0) + (32'(rs2) << 20) + (32'(rs1) << 15)
      + (32'(f3[op]) << 12) + (32'(rd) << 7) + 32'h33;
    return 1'b1;
  endfunction

  // Reference model state.
  logic [31:0] q [$];
  int          m_cnt;
  bit          m_err;
  logic [31:0] m_word;
  bit          m_legal;
  bit          m_acc;
  bit          m_pop;

  // Model advances on each clock edge from the inputs presented before it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      m_err = 0;
    end else begin
      m_err = 0;
      if (flush) begin
        q.delete();
      end else begin
        m_pop   = (q.size() > 0) && bus.out_ready;
        m_acc   = bus.in_valid && (q.size() < DEPTH);
        m_legal = model_encode(bus.in_alu_control, bus.in_rd, bus.in_rs1, bus.in_rs2, m_word);
        if (m_pop) void'(q.pop_front());
        if (m_acc) begin
          if (m_legal) q.push_back(m_word);
          else begin
            m_err = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      check("out_inst", bus.out_inst, (q.size() != 0) ? q[0] : 32'h0);
      check("fill_level", 32'(fill_level), 32'(q.size()));
      check("in_ready", 32'(bus.in_ready), 32'((q.size() < DEPTH) && !flush));
      check("err_illegal", 32'(err_illegal), 32'(m_err));
      check("illegal_count", 32'(illegal_count), 32'(m_cnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [4:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2);
    bus.in_valid       = 1'b1;
    bus.in_alu_control = op;
    bus.in_rd          = rd;
    bus.in_rs1         = rs1;
    bus.in_rs2         = rs2;
  endtask

  task automatic req_rand_legal();
    req(5'($urandom_range(0, 9)), 5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_alu_control = '0;
    bus.in_rd = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.out_ready = 1'b0;

    // Reset values while held in reset.
    #22;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_fill", 32'(fill_level), 32'h0);
    check("rst_err", 32'(err_illegal), 32'h0);
    check("rst_count", 32'(illegal_count), 32'h0);
    rst_n = 1'b1;
    cyc();
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // ADD rd=3 rs1=1 rs2=2.
    req(OP_ADD, 5'd3, 5'd1, 5'd2);
    cyc();
    idle();
    check("add_valid", 32'(bus.out_valid), 32'h1);
    check("add_inst", bus.out_inst, 32'h002081B3);
    check("add_fill", 32'(fill_level), 32'h1);
    bus.out_ready = 1'b1;
    cyc();

    // SUB then SRA streamed through with out_ready held high.
    req(OP_SUB, 5'd5, 5'd6, 5'd7);
    cyc();
    check("sub_inst", bus.out_inst, 32'h407302B3);
    req(OP_SRA, 5'd1, 5'd2, 5'd3);
    cyc();
    idle();
    check("sra_inst", bus.out_inst, 32'h403150B3);
    check("sra_fill", 32'(fill_level), 32'h1);
    cyc();
    check("stream_drained", 32'(fill_level), 32'h0);
    bus.out_ready = 1'b0;

    // Fill to DEPTH, hold a fifth request, then release.
    for (int i = 0; i < DEPTH; i++) begin
      req_rand_legal();
      cyc();
    end
    req_rand_legal();
    check("full_ready", 32'(bus.in_ready), 32'h0);
    check("full_fill", 32'(fill_level), 32'(DEPTH));
    cyc();
    check("full_held", 32'(fill_level), 32'(DEPTH));
    bus.out_ready = 1'b1;
    cyc();
    check("full_pop_only", 32'(fill_level), 32'(DEPTH - 1));
    check("full_ready_back", 32'(bus.in_ready), 32'h1);
    cyc();
    idle();
    check("full_push_pop", 32'(fill_level), 32'(DEPTH - 1));
    repeat (DEPTH) cyc();
    check("full_drained", 32'(fill_level), 32'h0);
    bus.out_ready = 1'b0;

    // Single illegal op.
    req(5'd10, 5'd1, 5'd1, 5'd1);
    check("ill_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    idle();
    check("ill_err", 32'(err_illegal), 32'h1);
    check("ill_count", 32'(illegal_count), 32'h1);
    check("ill_no_enq", 32'(fill_level), 32'h0);
    cyc();
    check("ill_err_pulse", 32'(err_illegal), 32'h0);

    // 300 illegal ops saturate the counter.
    for (int i = 0; i < 300; i++) begin
      req(5'($urandom_range(10, 31)), 5'($urandom), 5'($urandom), 5'($urandom));
      cyc();
    end
    idle();
    check("ill_saturate", 32'(illegal_count), 32'(CNT_MAX));

    // Flush with three words queued and both channels active.
    for (int i = 0; i < 3; i++) begin
      req_rand_legal();
      cyc();
    end
    check("pre_flush_fill", 32'(fill_level), 32'h3);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    req_rand_legal();
    cyc();
    flush = 1'b0;
    idle();
    bus.out_ready = 1'b0;
    check("flush_fill", 32'(fill_level), 32'h0);
    check("flush_valid", 32'(bus.out_valid), 32'h0);
    check("flush_count_kept", 32'(illegal_count), 32'(CNT_MAX));
    req(OP_AND, 5'd31, 5'd31, 5'd31);
    cyc();
    idle();
    check("and_inst", bus.out_inst, 32'h01FFFFB3);

    // Asynchronous reset mid-stream with two words queued.
    req_rand_legal();
    cyc();
    idle();
    check("pre_rst_fill", 32'(fill_level), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(bus.out_valid), 32'h0);
    check("async_fill", 32'(fill_level), 32'h0);
    check("async_count", 32'(illegal_count), 32'h0);
    #9;
    rst_n = 1'b1;
    cyc();
    req(OP_ADD, 5'd3, 5'd1, 5'd2);
    cyc();
    idle();
    check("post_rst_inst", bus.out_inst, 32'h002081B3);
    bus.out_ready = 1'b1;
    cyc();

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 9) == 0)
          req(5'($urandom_range(10, 31)), 5'($urandom), 5'($urandom), 5'($urandom));
        else
          req_rand_legal();
      end else begin
        idle();
      end
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 31) == 0);
      cyc();
    end
    idle();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (DEPTH + 2) cyc();
    check("final_drain", 32'(fill_level), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encode_reg_inst.md
Name: encode_reg_inst

Overview:
Inverse of the R-type decode path: turns an ALU operation plus register indices into a 32-bit RV32I R-type instruction word. It buffers encoded words in a small FIFO with valid/ready on both sides. It feeds the instruction-memory loader and the self-checking bench that drives the decoder. Illegal ALU codes are dropped and counted.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 8, width of the saturating illegal-op counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of FIFO contents; counter is kept
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_alu_control  in  5  op code from the shared ALU defines (`ADD, `SUB, `SLL, `SLT, `SLTU, `XOR, `SRL, `SRA, `OR, `AND)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
out_valid  out  1  encoded word available
out_ready  in  1  consumer takes word when out_valid && out_ready
out_inst  out  32  encoded instruction at FIFO head
err_illegal  out  1  one-cycle pulse, cycle after an illegal op is accepted
illegal_count  out  CNT_W  saturating count of illegal ops
fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): FIFO empty, pointers 0, out_valid=0, out_inst=0, err_illegal=0, illegal_count=0, fill_level=0, in_ready=1 after reset release.
- Encoding: inst = {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
- funct3/funct7 by op: ADD 000/0x00, SUB 000/0x20, SLL 001/0x00, SLT 010/0x00, SLTU 011/0x00, XOR 100/0x00, SRL 101/0x00, SRA 101/0x20, OR 110/0x00, AND 111/0x00.
- Any other in_alu_control value is illegal: accepted (consumes the handshake), not enqueued, err_illegal=1 the next cycle, illegal_count += 1, saturating at all-ones.
- in_ready = !full && !flush. Ready does not depend on in_valid. Full is never bypassed: a pop while full frees a slot only from the next cycle.
- Latency: a legal op accepted at edge N gives out_valid=1 and out_inst set after edge N, so visible in cycle N+1 when the FIFO was empty. No combinational in->out path.
- out_inst is driven from the head entry. It is 0 when empty. It holds stable while out_valid && !out_ready.
- Simultaneous push and pop when 0 < level < DEPTH: both happen, level unchanged, order preserved.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Level is tracked separately to tell full from empty.
- flush=1: at the edge, pointers and level go to 0 and out_valid drops. Any push or pop that cycle is ignored. illegal_count is kept. err_illegal is not raised for that cycle's input.
- Reset asserted mid-operation clears everything immediately (async). No partial word is emitted after release.

Test Plan:
- Reset, then ADD rd=3 rs1=1 rs2=2 -> out_valid next cycle, out_inst=0x002081B3, fill_level=1.
- SUB rd=5 rs1=6 rs2=7, then SRA rd=1 rs1=2 rs2=3, with out_ready=1 -> words 0x407302B3 then 0x403150B3, in order.
- Push 5 ops with out_ready=0 and DEPTH=4 -> in_ready=0 after the 4th accept, fill_level=4, 5th held. Raise out_ready -> 5th accepted the cycle after the first pop, order preserved.
- Illegal code (an unused 5-bit value) with in_valid=1 -> in_ready=1, no enqueue, err_illegal pulses 1 cycle, illegal_count=1. Drive 300 illegals with CNT_W=8 -> count saturates at 255.
- FIFO holding 3 words, flush=1 with in_valid=1 and out_ready=1 -> next cycle fill_level=0, out_valid=0, no word consumed or added. AND rd=31 rs1=31 rs2=31 afterwards -> 0x01FFFFB3.
- Deassert rst_n mid-stream with 2 words queued -> out_valid=0 and fill_level=0 immediately without a clock edge. Normal operation after release.
